// File: rtl/i2s_xmtr.sv
// I2S master transmitter: divides clk into bck/lrck and shifts stereo pairs out MSB-first.
// Define I2S_XMTR_REPEAT_ON_UNDERRUN_EN to resend the previous pair on underrun instead of silence.
module i2s_xmtr #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  output logic                  bck,
  output logic                  lrck,
  output logic                  data,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int DIV_W = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam int CNT_W = (SLOT_WIDTH > 2) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SLOT_WIDTH - 1);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  chan_e                 chan_q, chan_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  bck_q, bck_d;
  logic                  lrck_q, lrck_d;
  logic                  data_q, data_d;
  logic                  s_ready_q, s_ready_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] buf_left_q, buf_left_d;
  logic [DATA_WIDTH-1:0] buf_right_q, buf_right_d;
  logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  logic             accept;
  logic             fall_tick;
  logic             take_buf;
  logic [CNT_W-1:0] bit_next;

  always_comb begin
    chan_d        = chan_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    bck_d         = bck_q;
    lrck_d        = lrck_q;
    data_d        = data_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    shift_d       = shift_q;
    take_buf      = 1'b0;

    accept    = s_valid && s_ready_q;
    fall_tick = en && (div_cnt_q == DIV_LAST);
    bit_next  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);

    if (!en) begin
      chan_d       = CH_RIGHT;
      div_cnt_d    = '0;
      bit_cnt_d    = BIT_LAST;
      bck_d        = 1'b0;
      lrck_d       = 1'b1;
      data_d       = 1'b0;
      hold_left_d  = '0;
      hold_right_d = '0;
      shift_d      = '0;
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      if (div_cnt_q == DIV_RISE) begin
        bck_d = 1'b1;
      end
      if (fall_tick) begin
        bck_d     = 1'b0;
        bit_cnt_d = bit_next;
        if (bit_next == '0) begin
          // Slot boundary: bit 0 of every slot is the I2S one-bit delay, always 0.
          lrck_d = ~lrck_q;
          data_d = 1'b0;
          if (chan_q == CH_RIGHT) begin
            chan_d        = CH_LEFT;
            frame_start_d = 1'b1;
            if (buf_full_q) begin
              hold_left_d  = buf_left_q;
              hold_right_d = buf_right_q;
              take_buf     = 1'b1;
            end else begin
              underrun_d = 1'b1;
`ifndef I2S_XMTR_REPEAT_ON_UNDERRUN_EN
              hold_left_d  = '0;
              hold_right_d = '0;
`endif
            end
            shift_d = hold_left_d;
          end else begin
            chan_d  = CH_RIGHT;
            shift_d = hold_right_q;
          end
        end else begin
          // Zeros shift in behind the sample, so bits past DATA_WIDTH come out as 0.
          data_d  = shift_q[DATA_WIDTH-1];
          shift_d = shift_q << 1;
        end
      end
    end

    // The buffer can't be full and accepting at once, so take and accept never collide.
    buf_full_d = buf_full_q;
    if (accept) begin
      buf_left_d  = s_left;
      buf_right_d = s_right;
      buf_full_d  = 1'b1;
    end else if (take_buf) begin
      buf_full_d = 1'b0;
    end
    s_ready_d = !buf_full_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_q        <= CH_RIGHT;
      div_cnt_q     <= '0;
      bit_cnt_q     <= BIT_LAST;
      bck_q         <= 1'b0;
      lrck_q        <= 1'b1;
      data_q        <= 1'b0;
      s_ready_q     <= 1'b1;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      shift_q       <= '0;
    end else begin
      chan_q        <= chan_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bck_q         <= bck_d;
      lrck_q        <= lrck_d;
      data_q        <= data_d;
      s_ready_q     <= s_ready_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      buf_full_q    <= buf_full_d;
      buf_left_q    <= buf_left_d;
      buf_right_q   <= buf_right_d;
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      shift_q       <= shift_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign bck         = bck_q;
  assign lrck        = lrck_q;
  assign data        = data_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_xmtr.sv
// Bench for i2s_xmtr: directed phases with random data, checked every clk against a
// timeline model that derives bck/lrck/data from the number of enabled clocks.
module tb_i2s_xmtr;

  localparam int DW = 24;
  localparam int SW = 32;
  localparam int BD = 2;
  localparam int FRAME_CLKS = 2 * SW * BD;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          s_valid;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;
  logic          s_ready;
  logic          bck;
  logic          lrck;
  logic          data;
  logic          frame_start;
  logic          underrun;

  // Model: clocks since enable, one-entry buffer, and the pair owned by the current frame.
  int            n;
  bit            m_full;
  logic [DW-1:0] m_bl, m_br, m_hl, m_hr;
  bit            m_fs, m_ur;
  int            vectors;
  int            miscompares;
  bit            found;

  i2s_xmtr #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCK_DIV(BD)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_left      (s_left),
    .s_right     (s_right),
    .bck         (bck),
    .lrck        (lrck),
    .data        (data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at %0t: observed %b, expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_full = 0;
    m_bl   = '0;
    m_br   = '0;
    m_hl   = '0;
    m_hr   = '0;
    m_fs   = 0;
    m_ur   = 0;
  endtask

  task automatic model_step();
    bit acc;
    if (reset) begin
      model_reset();
    end else begin
      acc  = s_valid && !m_full;
      m_fs = 0;
      m_ur = 0;
      if (!en) begin
        n    = 0;
        m_hl = '0;
        m_hr = '0;
      end else begin
        n++;
        if ((n % BD) == 0 && ((n / BD - 1) % (2 * SW)) == 0) begin
          m_fs = 1;
          if (m_full) begin
            m_hl   = m_bl;
            m_hr   = m_br;
            m_full = 0;
          end else begin
            m_ur = 1;
`ifndef I2S_XMTR_REPEAT_ON_UNDERRUN_EN
            m_hl = '0;
            m_hr = '0;
`endif
          end
        end
      end
      if (acc) begin
        m_bl   = s_left;
        m_br   = s_right;
        m_full = 1;
      end
    end
  endtask

  task automatic check_all();
    logic          e_bck, e_lrck, e_data;
    logic [DW-1:0] smp;
    int            g, k;
    e_bck  = 1'b0;
    e_lrck = 1'b1;
    e_data = 1'b0;
    if (n > 0) begin
      e_bck = ((n % BD) >= BD / 2);
      if (n / BD > 0) begin
        g      = n / BD - 1;
        k      = g % SW;
        e_lrck = ((g / SW) % 2) == 1;
        smp    = e_lrck ? m_hr : m_hl;
        if (k >= 1 && k <= DW) e_data = smp[DW-k];
      end
    end
    chk("bck", bck, e_bck);
    chk("lrck", lrck, e_lrck);
    chk("data", data, e_data);
    chk("s_ready", s_ready, !m_full);
    chk("frame_start", frame_start, m_fs);
    chk("underrun", underrun, m_ur);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  function automatic bit next_is_fs();
    return en && ((n + 1) % BD == 0) && ((((n + 1) / BD) - 1) % (2 * SW) == 0);
  endfunction

  task automatic wait_fs();
    found = 0;
    for (int i = 0; i < FRAME_CLKS + 2 * BD && !found; i++) begin
      if (next_is_fs()) found = 1;
      else tick();
    end
    chk("wait_frame_start", found, 1'b1);
  endtask

  task automatic wait_slot(input int want_chan, input int want_k);
    found = 0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      if (n >= BD && (n % BD) == 0 && (((n / BD - 1) / SW) % 2) == want_chan &&
          ((n / BD - 1) % SW) == want_k) found = 1;
      else tick();
    end
    chk("wait_slot", found, 1'b1);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    en          = 1'b0;
    s_valid     = 1'b0;
    s_left      = '0;
    s_right     = '0;
    model_reset();
    #1;
    check_all();
    run(2);
    reset = 1'b0;

    // Free-running with no samples: every frame underruns and data stays 0.
    en = 1'b1;
    run(2 * FRAME_CLKS + 10);

    // Known pair loaded while idle goes out in the first frame.
    async_reset();
    en      = 1'b0;
    s_valid = 1'b1;
    s_left  = 24'hA5A5A5;
    s_right = 24'h123456;
    tick();
    s_valid = 1'b0;
    tick();
    en = 1'b1;
    run(FRAME_CLKS + 10);

    // Continuous valid with an incrementing pattern: one pair per frame.
    s_valid = 1'b1;
    s_left  = 24'h000100;
    s_right = 24'hF00001;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      automatic bit will_accept = !m_full;
      tick();
      if (will_accept) begin
        s_left  = s_left + 24'd1;
        s_right = s_right - 24'd3;
      end
    end
    s_valid = 1'b0;

    // Pair offered exactly on a frame start with the buffer empty.
    wait_fs();
    tick();
    wait_fs();
    s_valid = 1'b1;
    s_left  = DW'($urandom);
    s_right = DW'($urandom);
    tick();
    s_valid = 1'b0;
    run(2 * FRAME_CLKS);

    // Random valid traffic and data.
    for (int i = 0; i < 6 * FRAME_CLKS; i++) begin
      s_valid = ($urandom_range(0, 40) == 0);
      s_left  = DW'($urandom);
      s_right = DW'($urandom);
      tick();
    end
    s_valid = 1'b0;

    // Disable mid right slot with a pair pending, then re-enable.
    wait_slot(1, 4);
    s_valid = 1'b1;
    s_left  = DW'($urandom);
    s_right = DW'($urandom);
    tick();
    s_valid = 1'b0;
    en      = 1'b0;
    run(3);
    en = 1'b1;
    run(FRAME_CLKS + 10);

    // Reset mid left slot with a full buffer; the following frame underruns.
    wait_slot(0, 6);
    s_valid = 1'b1;
    s_left  = DW'($urandom);
    s_right = DW'($urandom);
    tick();
    s_valid = 1'b0;
    async_reset();
    run(FRAME_CLKS + 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
